alu_cmd_sequencer: RTL

- Command-side master for the registered 16-bit ALU.
- Accepts one operation at a time (opcode plus two operands) on a valid/ready command channel and drives the ALU's A, B and function inputs from registers.
- Waits out the ALU's output register latency, captures the output group selected by the opcode, and returns one normalised result on a valid/ready response channel.
- Sits between a host/command FSM and the ALU.

---
 rtl/alu_cmd_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command-side master for the registered ALU: one op in flight, ALU latency wait, group-selected result out.
// Optional build macro ALU_SEQ_OPCNT_EN adds a saturating completed-op counter (op_count) with clear (op_count_clr).
module alu_cmd_sequencer #(
  parameter int IN_DATA_WIDTH   = 16,
  parameter int Arith_OUT_WIDTH = 32,
  parameter int Logic_OUT_WIDTH = 16,
  parameter int Shift_OUT_WIDTH = 16,
  parameter int CMP_OUT_WIDTH   = 3,
  parameter int ALU_LATENCY     = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [3:0]                 cmd_op,
  input  logic [IN_DATA_WIDTH-1:0]   cmd_a,
  input  logic [IN_DATA_WIDTH-1:0]   cmd_b,
  output logic [IN_DATA_WIDTH-1:0]   alu_a,
  output logic [IN_DATA_WIDTH-1:0]   alu_b,
  output logic [3:0]                 alu_func,
  input  logic [Arith_OUT_WIDTH-1:0] Arith_OUT,
  input  logic                       Carry_OUT,
  input  logic                       Arith_Flag,
  input  logic [Logic_OUT_WIDTH-1:0] Logic_OUT,
  input  logic                       Logic_Flag,
  input  logic [Shift_OUT_WIDTH-1:0] Shift_OUT,
  input  logic                       Shift_Flag,
  input  logic [CMP_OUT_WIDTH-1:0]   CMP_OUT,
  input  logic                       CMP_Flag,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [Arith_OUT_WIDTH-1:0] rsp_data,
  output logic                       rsp_carry,
  output logic                       rsp_flag,
  output logic [2:0]                 state_dbg
`ifdef ALU_SEQ_OPCNT_EN
  ,
  input  logic                       op_count_clr,
  output logic [15:0]                op_count
`endif
);

  // Both channels: a transfer happens on a rising edge where valid && ready;
  // valid, once raised, holds its payload stable until that edge.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              state, state_nx;
  logic [CNT_W-1:0]    wait_cnt, wait_cnt_nx;
  logic [1:0]          group_q;
  logic                cmd_hs;
  logic [Arith_OUT_WIDTH-1:0] cap_data;
  logic                cap_carry;
  logic                cap_flag;

  assign cmd_hs    = cmd_valid && cmd_ready;
  assign state_dbg = state;

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        wait_cnt_nx = CNT_LOAD;
        state_nx    = (ALU_LATENCY == 1) ? S_CAPTURE : S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_nx = wait_cnt - CNT_ONE;
        if (wait_cnt <= CNT_ONE) state_nx = S_CAPTURE;
      end
      S_CAPTURE: state_nx = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Narrow groups are zero-extended; carry only means something for arith.
  always_comb begin
    cap_data  = '0;
    cap_carry = 1'b0;
    cap_flag  = 1'b0;
    case (group_q)
      2'b00: begin
        cap_data  = Arith_OUT;
        cap_carry = Carry_OUT;
        cap_flag  = Arith_Flag;
      end
      2'b01: begin
        cap_data = {{(Arith_OUT_WIDTH-Logic_OUT_WIDTH){1'b0}}, Logic_OUT};
        cap_flag = Logic_Flag;
      end
      2'b10: begin
        cap_data = {{(Arith_OUT_WIDTH-CMP_OUT_WIDTH){1'b0}}, CMP_OUT};
        cap_flag = CMP_Flag;
      end
      default: begin
        cap_data = {{(Arith_OUT_WIDTH-Shift_OUT_WIDTH){1'b0}}, Shift_OUT};
        cap_flag = Shift_Flag;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      group_q   <= 2'b00;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_func  <= 4'h0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_flag  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      // ALU drive registers change only on acceptance and otherwise hold.
      if (cmd_hs) begin
        alu_a    <= cmd_a;
        alu_b    <= cmd_b;
        alu_func <= cmd_op;
        group_q  <= cmd_op[3:2];
      end
      if (state == S_CAPTURE) begin
        rsp_data  <= cap_data;
        rsp_carry <= cap_carry;
        rsp_flag  <= cap_flag;
      end
    end
  end

`ifdef ALU_SEQ_OPCNT_EN
  logic rsp_hs;
  assign rsp_hs = rsp_valid && rsp_ready;

  // Clear beats a coinciding completion; the count sticks at all-ones.
  always_ff @(posedge CLK) begin
    if (RST || op_count_clr) begin
      op_count <= 16'h0000;
    end else if (rsp_hs && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'h0001;
    end
  end
`endif

endmodule
